proc_trace_buf: RTL
===================

PROC_TRACE_BUF -- requirements
Module: proc_trace_buf

Interface
REQ-001 Parameter DEPTH, default 16, sets buffer entries; SHALL be a power of two, 2..256.
REQ-002 Parameter WRAP, default 1, selects full-buffer policy: 1 = overwrite oldest, 0 = stop capture.
REQ-003 Parameter CW = $clog2(DEPTH)+1, derived, SHALL size the entry counter.
REQ-004 clk  in  1  single clock; all state changes on posedge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 trace_val  in  1  trace record valid this cycle.
REQ-007 trace_addr / trace_inst / trace_data  in  32 each  retired-instruction PC, encoding, writeback/store data.
REQ-008 cfg_mode  in  2  capture filter: 00 all, 01 stores only (trace_inst[6:0]==7'b0100011), 10 address window, 11 reserved (treated as 00).
REQ-009 cfg_lo / cfg_hi  in  32 each  inclusive window bounds on trace_addr for mode 10.
REQ-010 arm  in  1  single-cycle request to clear and start capture.
REQ-011 stop  in  1  single-cycle request to end capture.
REQ-012 rd_rdy  in  1  consumer accepts readout record.
REQ-013 rd_val  out  1  readout record valid.
REQ-014 rd_addr / rd_inst / rd_data  out  32 each  oldest buffered record.
REQ-015 count  out  CW  entries currently held.
REQ-016 overflow  out  1  sticky: a record was overwritten (WRAP=1) or dropped (WRAP=0).
REQ-017 state  out  2  00 IDLE, 01 CAPTURE, 10 DONE.

Function
REQ-018 Record qualifies when trace_val=1, state=CAPTURE, and filter passes; cfg_* sampled the same cycle.
REQ-019 Qualifying record SHALL be written at posedge; count increments visibly next cycle (1-cycle latency).
REQ-020 Mode 10 passes iff cfg_lo <= trace_addr <= cfg_hi unsigned; cfg_lo > cfg_hi passes nothing.
REQ-021 Write/read pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-022 Full (count==DEPTH), WRAP=1: record written at oldest slot, read pointer advances, count holds DEPTH, overflow set.
REQ-023 Full, WRAP=0: record dropped, overflow set, state -> DONE next cycle.
REQ-024 IDLE: arm -> CAPTURE; pointers, count, overflow cleared same edge; stop ignored.
REQ-025 CAPTURE: stop -> DONE; a qualifying record in the stop cycle IS captured.
REQ-026 CAPTURE: arm (without stop) -> re-clear, remain CAPTURE; record in that cycle discarded.
REQ-027 arm and stop same cycle: stop wins.
REQ-028 DONE: rd_val = (count!=0); rd_* SHALL show entry at read pointer, combinationally from storage.
REQ-029 DONE: rd_val & rd_rdy pops one entry per cycle, oldest first; count decrements next cycle.
REQ-030 DONE with count==0 (including after last pop) -> IDLE next cycle; overflow retained until next arm.
REQ-031 DONE: arm -> clear and CAPTURE, abandoning unread entries; pop that cycle suppressed.
REQ-032 rd_val SHALL be 0 outside DONE; rd_* undefined when rd_val=0.
REQ-033 Trace inputs SHALL be ignored outside CAPTURE.

Reset
REQ-034 rst=0 at posedge: state=IDLE, count=0, overflow=0, pointers=0, rd_val=0 next cycle; overrides arm/stop/rd_rdy.
REQ-035 Reset mid-CAPTURE or mid-readout SHALL discard all entries; storage contents need not be cleared.

Verification
REQ-036 DEPTH=4, mode 00: arm, 3 records addr 0x000,0x004,0x008, stop -> DONE, count=3, rd_rdy=1 yields 0x000,0x004,0x008 on consecutive cycles, then IDLE.
REQ-037 DEPTH=4, WRAP=1: 6 records addr 0x00..0x14 step 4, stop -> count=4, overflow=1, readout 0x08,0x0C,0x10,0x14.
REQ-038 DEPTH=4, WRAP=0: 5 records -> DONE automatically after 5th, overflow=1, readout first 4 only.
REQ-039 Mode 01: interleave add (0x00b50533) and sw (0x00b52023) encodings -> only sw records captured; mode 10 window 0x100..0x10C over addrs 0x0FC..0x110 step 4 -> 4 captured.
REQ-040 Arm+stop same cycle in CAPTURE -> DONE; rd_rdy held low 3 cycles -> rd_val and rd_addr stable; rst=0 mid-readout -> IDLE, count=0, rd_val=0 next cycle.

Source files
------------

// File: rtl/proc_trace_buf.sv
// Purpose: filtered retired-instruction trace capture into a circular buffer, with readout in oldest-first order.
// Latency: a captured record shows in count one cycle after its edge; readout data is combinational from storage.
// Backpressure: readout pops only on rd_val & rd_rdy; a full buffer overwrites the oldest record (WRAP=1) or stops capture (WRAP=0).
module proc_trace_buf #(
  parameter int DEPTH = 16,
  parameter bit WRAP  = 1'b1,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          trace_val,
  input  logic [31:0]   trace_addr,
  input  logic [31:0]   trace_inst,
  input  logic [31:0]   trace_data,
  input  logic [1:0]    cfg_mode,
  input  logic [31:0]   cfg_lo,
  input  logic [31:0]   cfg_hi,
  input  logic          arm,
  input  logic          stop,
  input  logic          rd_rdy,
  output logic          rd_val,
  output logic [31:0]   rd_addr,
  output logic [31:0]   rd_inst,
  output logic [31:0]   rd_data,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic [1:0]    state
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] data;
  } rec_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_CAPTURE = 2'b01,
    S_DONE    = 2'b10
  } state_t;

  rec_t          mem [DEPTH];
  rec_t          rec_in;
  rec_t          rec_out;
  state_t        st;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          filt_pass;
  logic          qual;
  logic          full;
  logic          wr_en;
  logic          ovf_q;

  // Capture filter: mode 11 behaves like mode 00; an inverted window matches nothing.
  always_comb begin
    filt_pass = 1'b1;
    case (cfg_mode)
      2'b01:   filt_pass = (trace_inst[6:0] == 7'b0100011);
      2'b10:   filt_pass = (trace_addr >= cfg_lo) && (trace_addr <= cfg_hi);
      default: filt_pass = 1'b1;
    endcase
  end

  assign rec_in = '{addr: trace_addr, inst: trace_inst, data: trace_data};
  assign qual   = (st == S_CAPTURE) && trace_val && filt_pass;
  assign full   = (cnt == CW'(DEPTH));
  // A re-arm (arm without stop) discards the record of that cycle; a full non-wrapping buffer drops it.
  assign wr_en  = qual && (stop || !arm) && (!full || WRAP);

  // Record storage; contents are never cleared, pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= rec_in;
    end
  end

  // Control FSM: capture bookkeeping, overflow tracking and readout pops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      st     <= S_IDLE;
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          if (arm) begin
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
            st     <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (arm && !stop) begin
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
          end else begin
            if (qual) begin
              if (!full) begin
                wr_ptr <= wr_ptr + AW'(1);
                cnt    <= cnt + CW'(1);
              end else if (WRAP) begin
                wr_ptr <= wr_ptr + AW'(1);
                rd_ptr <= rd_ptr + AW'(1);
                ovf_q  <= 1'b1;
              end else begin
                ovf_q  <= 1'b1;
                st     <= S_DONE;
              end
            end
            if (stop) begin
              st <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (arm) begin
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
            st     <= S_CAPTURE;
          end else if (cnt == '0) begin
            st <= S_IDLE;
          end else if (rd_rdy) begin
            rd_ptr <= rd_ptr + AW'(1);
            cnt    <= cnt - CW'(1);
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  // Readout view: oldest record straight from storage, valid only while draining.
  assign rec_out  = mem[rd_ptr];
  assign rd_val   = (st == S_DONE) && (cnt != '0);
  assign rd_addr  = rec_out.addr;
  assign rd_inst  = rec_out.inst;
  assign rd_data  = rec_out.data;
  assign count    = cnt;
  assign overflow = ovf_q;
  assign state    = st;

endmodule
